rr_arb_mux: RTL and testbench

- Parametrised N-to-1 data multiplexer whose select is generated internally by an arbiter, not driven externally.
- Each input is a valid/ready channel. The block picks one requesting channel per cycle, using round-robin or fixed priority, and registers the chosen beat into a single output stage.
- Multi-beat bursts hold the grant until the last beat.
- Sits in front of shared processor resources (writeback port, memory request bus) where several producers compete for one consumer.

---
 rtl/rr_arb_mux.sv | 116 +++++++++++
 tb/tb_rr_arb_mux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N:1 valid/ready mux with internal round-robin or fixed-priority arbiter; one register stage, 1-cycle latency.
// Backpressure: o_ready is zero whenever the output register is full and not draining; bursts keep the grant.
module rr_arb_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 1,
  localparam int SELECT_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  output logic [NUM_INPUTS-1:0]            o_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_INPUTS-1:0]            i_last,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [SELECT_BITS-1:0]           o_select,
  output logic                             o_last
);

  logic [SELECT_BITS-1:0] ptr;
  logic                   lock;
  logic [SELECT_BITS-1:0] lock_ch;

  logic                   grant_vld;
  logic [SELECT_BITS-1:0] grant;
  logic [DATA_WIDTH-1:0]  grant_dat;
  logic                   grant_last;
  logic                   load_en;
  logic                   accept;

  function automatic int wrap(input int a);
    return (a >= NUM_INPUTS) ? a - NUM_INPUTS : a;
  endfunction

  // Arbiter: a held lock restricts eligibility to the bursting channel only.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (lock) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (lock_ch == SELECT_BITS'(k) && i_valid[k]) begin
          grant_vld = 1'b1;
          grant     = SELECT_BITS'(k);
        end
      end
    end else if (ROUND_ROBIN != 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          if (!grant_vld && k == wrap(int'(ptr) + i) && i_valid[k]) begin
            grant_vld = 1'b1;
            grant     = SELECT_BITS'(k);
          end
        end
      end
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (!grant_vld && i_valid[k]) begin
          grant_vld = 1'b1;
          grant     = SELECT_BITS'(k);
        end
      end
    end
  end

  always_comb begin
    grant_dat  = '0;
    grant_last = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant == SELECT_BITS'(k)) begin
        grant_dat  = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        grant_last = i_last[k];
      end
    end
  end

  assign load_en = !o_valid || i_ready;
  // Reset wins over a same-cycle handshake, so no producer sees an accept that gets dropped.
  assign accept  = load_en && grant_vld && !i_rst;

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      o_ready[k] = accept && (grant == SELECT_BITS'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_select <= '0;
      o_last   <= 1'b0;
      ptr      <= '0;
      lock     <= 1'b0;
      lock_ch  <= '0;
    end else if (load_en) begin
      o_valid <= accept;
      if (accept) begin
        o_data   <= grant_dat;
        o_select <= grant;
        o_last   <= grant_last;
        // Pointer moves only on last beats so fairness is counted per burst.
        if (grant_last) begin
          lock <= 1'b0;
          ptr  <= (grant == SELECT_BITS'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
        end else begin
          lock    <= 1'b1;
          lock_ch <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: 4x32 round-robin instance plus 3x8 fixed-priority and round-robin instances.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 4-input, 32-bit, round-robin
  logic [3:0]   valid4, ready4, last4;
  logic [127:0] dbus4;
  logic         ov4, irdy4, olast4;
  logic [31:0]  od4;
  logic [1:0]   osel4;

  // 3-input, 8-bit, fixed priority
  logic [2:0]   valid_fp, ready_fp, last_fp;
  logic [23:0]  dbus_fp;
  logic         ov_fp, irdy_fp, olast_fp;
  logic [7:0]   od_fp;
  logic [1:0]   osel_fp;

  // 3-input, 8-bit, round-robin
  logic [2:0]   valid_r3, ready_r3, last_r3;
  logic [23:0]  dbus_r3;
  logic         ov_r3, irdy_r3, olast_r3;
  logic [7:0]   od_r3;
  logic [1:0]   osel_r3;

  rr_arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(32), .ROUND_ROBIN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid4), .o_ready(ready4),
    .i_data_bus(dbus4), .i_last(last4), .o_valid(ov4), .i_ready(irdy4),
    .o_data(od4), .o_select(osel4), .o_last(olast4)
  );

  rr_arb_mux #(.NUM_INPUTS(3), .DATA_WIDTH(8), .ROUND_ROBIN(0)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_fp), .o_ready(ready_fp),
    .i_data_bus(dbus_fp), .i_last(last_fp), .o_valid(ov_fp), .i_ready(irdy_fp),
    .o_data(od_fp), .o_select(osel_fp), .o_last(olast_fp)
  );

  rr_arb_mux #(.NUM_INPUTS(3), .DATA_WIDTH(8), .ROUND_ROBIN(1)) dut_r3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_r3), .o_ready(ready_r3),
    .i_data_bus(dbus_r3), .i_last(last_r3), .o_valid(ov_r3), .i_ready(irdy_r3),
    .o_data(od_r3), .o_select(osel_r3), .o_last(olast_r3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 2 units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] d4(input int ch);
    return 32'hC0DE_0000 | 32'(ch);
  endfunction

  initial begin
    rst = 1'b1;
    valid4 = 4'b1111; last4 = 4'b1111; irdy4 = 1'b1;
    for (int k = 0; k < 4; k++) dbus4[k*32 +: 32] = d4(k);
    valid_fp = 3'b000; last_fp = 3'b111; irdy_fp = 1'b1;
    valid_r3 = 3'b000; last_r3 = 3'b111; irdy_r3 = 1'b1;
    dbus_fp = {8'h22, 8'h11, 8'h00};
    dbus_r3 = {8'h22, 8'h11, 8'h00};

    // Reset held two cycles with every channel requesting
    tick(); tick();
    settle();
    chk("rst_o_valid", 64'(ov4), 64'd0);
    chk("rst_o_ready", 64'(ready4), 64'h0);
    chk("rst_o_data", 64'(od4), 64'h0);
    chk("rst_o_select", 64'(osel4), 64'd0);
    chk("rst_o_last", 64'(olast4), 64'd0);

    // Round-robin sweep, one beat per cycle
    rst = 1'b0;
    settle();
    chk("rr_first_ready", 64'(ready4), 64'b0001);
    tick();
    chk("rr_first_valid", 64'(ov4), 64'd1);
    chk("rr_first_sel", 64'(osel4), 64'd0);
    chk("rr_first_data", 64'(od4), 64'(d4(0)));
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("rr_ready", 64'(ready4), 64'(4'b0001 << (i % 4)));
      tick();
      chk("rr_valid", 64'(ov4), 64'd1);
      chk("rr_sel", 64'(osel4), 64'(i % 4));
      chk("rr_data", 64'(od4), 64'(d4(i % 4)));
    end

    // Backpressure: output holds channel-0 beat for 5 cycles
    irdy4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_ready", 64'(ready4), 64'h0);
      tick();
      chk("bp_valid", 64'(ov4), 64'd1);
      chk("bp_sel", 64'(osel4), 64'd0);
      chk("bp_data", 64'(od4), 64'(d4(0)));
    end
    irdy4 = 1'b1;
    settle();
    chk("bp_release_ready", 64'(ready4), 64'b0010);
    tick();
    chk("bp_release_valid", 64'(ov4), 64'd1);
    chk("bp_release_sel", 64'(osel4), 64'd1);

    // Burst lock: channel 1 sends three beats, channel 2 waits (pointer now 2)
    valid4 = 4'b0010; last4 = 4'b1101; dbus4[32 +: 32] = 32'hB000_0000;
    settle();
    chk("burst_b0_ready", 64'(ready4), 64'b0010);
    tick();
    chk("burst_b0_sel", 64'(osel4), 64'd1);
    chk("burst_b0_data", 64'(od4), 64'hB000_0000);
    chk("burst_b0_last", 64'(olast4), 64'd0);
    valid4 = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("burst_gap_ready", 64'(ready4), 64'h0);
      tick();
      chk("burst_gap_valid", 64'(ov4), 64'd0);
    end
    valid4 = 4'b0110; dbus4[32 +: 32] = 32'hB000_0001;
    settle();
    chk("burst_b1_ready", 64'(ready4), 64'b0010);
    tick();
    chk("burst_b1_sel", 64'(osel4), 64'd1);
    chk("burst_b1_data", 64'(od4), 64'hB000_0001);
    last4 = 4'b1111; dbus4[32 +: 32] = 32'hB000_0002;
    settle();
    chk("burst_b2_ready", 64'(ready4), 64'b0010);
    tick();
    chk("burst_b2_sel", 64'(osel4), 64'd1);
    chk("burst_b2_data", 64'(od4), 64'hB000_0002);
    chk("burst_b2_last", 64'(olast4), 64'd1);
    valid4 = 4'b0100;
    settle();
    chk("burst_after_ready", 64'(ready4), 64'b0100);
    tick();
    chk("burst_after_sel", 64'(osel4), 64'd2);
    chk("burst_after_data", 64'(od4), 64'(d4(2)));

    // Reset in the middle of a channel-3 burst
    valid4 = 4'b1000; last4 = 4'b0111;
    settle();
    chk("mid_b0_ready", 64'(ready4), 64'b1000);
    tick();
    chk("mid_b0_sel", 64'(osel4), 64'd3);
    chk("mid_b0_last", 64'(olast4), 64'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(ov4), 64'd0);
    chk("mid_rst_data", 64'(od4), 64'h0);
    rst = 1'b0; valid4 = 4'b0011; last4 = 4'b1111;
    settle();
    chk("mid_after_ready", 64'(ready4), 64'b0001);
    tick();
    chk("mid_after_valid", 64'(ov4), 64'd1);
    chk("mid_after_sel", 64'(osel4), 64'd0);

    // 3-input instances: fixed priority starves channel 2; round-robin wraps 2->0 onto channel 2
    valid_fp = 3'b110; valid_r3 = 3'b100;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("fp_ready", 64'(ready_fp), 64'b010);
      chk("r3_ready", 64'(ready_r3), 64'b100);
      tick();
      chk("fp_sel", 64'(osel_fp), 64'd1);
      chk("fp_data", 64'(od_fp), 64'h11);
      chk("r3_sel", 64'(osel_r3), 64'd2);
      chk("r3_data", 64'(od_r3), 64'h22);
    end
    valid_fp = 3'b111;
    settle();
    chk("fp_all_ready", 64'(ready_fp), 64'b001);
    tick();
    chk("fp_all_sel", 64'(osel_fp), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
